// File: rtl/scb_csla_pipe.sv
// Square-root carry-select adder/subtractor with optional per-group pipelining
// and a valid/ready handshake. Groups widen by one bit from a 2-bit base.

module scb_csla_grp #(
  parameter int GW    = 2,
  parameter bit FIRST = 1'b0
) (
  input  logic [GW-1:0] a_i,
  input  logic [GW-1:0] b_i,
  input  logic          c_i,
  output logic [GW-1:0] s_o,
  output logic          c_o
);
  generate
    if (FIRST) begin : g_plain
      logic [GW:0] r;
      assign r = {1'b0, a_i} + {1'b0, b_i} + {{GW{1'b0}}, c_i};
      assign {c_o, s_o} = r;
    end else begin : g_sel
      logic [GW:0] r0, r1, t;
      assign r0   = {1'b0, a_i} + {1'b0, b_i};
      // Binary-to-excess-one: bit i toggles when every bit below it is set.
      assign t[0] = 1'b1;
      for (genvar i = 0; i < GW; i++) begin : g_bec
        assign t[i+1] = t[i] & r0[i];
      end
      assign r1 = r0 ^ t;
      assign {c_o, s_o} = c_i ? r1 : r0;
    end
  endgenerate
endmodule

module scb_csla_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  function automatic int grp_lo(input int k);
    return 2 * k + (k * (k - 1)) / 2;
  endfunction

  function automatic int grp_w(input int k);
    int r;
    r = WIDTH - grp_lo(k);
    return (r < k + 2) ? r : k + 2;
  endfunction

  function automatic int num_grp(input int w);
    int g;
    g = 0;
    while (grp_lo(g) < w) g++;
    return g;
  endfunction

  localparam int G   = num_grp(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic             en;
  logic [WIDTH-1:0] ye;
  logic             ce;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign ye       = sub ? ~y : y;
  assign ce       = sub | cin;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] x_q [G];
      logic [WIDTH-1:0] y_q [G];
      logic [WIDTH-1:0] s_q [G];
      logic [G-1:0]     c_q, v_q;
      logic [WIDTH-1:0] x_src [G];
      logic [WIDTH-1:0] y_src [G];
      logic [WIDTH-1:0] s_src [G];
      logic [WIDTH-1:0] s_nxt [G];
      logic [G-1:0]     c_src, c_nxt, v_src;

      for (genvar k = 0; k < G; k++) begin : g_stg
        localparam int LO = grp_lo(k);
        localparam int GW = grp_w(k);
        logic [GW-1:0] gs;
        if (k == 0) begin : g_head
          assign x_src[k] = x;
          assign y_src[k] = ye;
          assign s_src[k] = '0;
          assign c_src[k] = ce;
          assign v_src[k] = in_valid;
        end else begin : g_link
          assign x_src[k] = x_q[k-1];
          assign y_src[k] = y_q[k-1];
          assign s_src[k] = s_q[k-1];
          assign c_src[k] = c_q[k-1];
          assign v_src[k] = v_q[k-1];
        end
        scb_csla_grp #(.GW(GW), .FIRST(k == 0)) u_grp (
          .a_i (x_src[k][LO +: GW]),
          .b_i (y_src[k][LO +: GW]),
          .c_i (c_src[k]),
          .s_o (gs),
          .c_o (c_nxt[k])
        );
        // Bits at and above LO are still zero in s_src, so OR merges the group in.
        assign s_nxt[k] = s_src[k] | (WIDTH'(gs) << LO);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          c_q <= '0;
          for (int i = 0; i < G; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
            s_q[i] <= '0;
          end
        end else if (en) begin
          v_q <= v_src;
          c_q <= c_nxt;
          for (int i = 0; i < G; i++) begin
            x_q[i] <= x_src[i];
            y_q[i] <= y_src[i];
            s_q[i] <= s_nxt[i];
          end
        end
      end

      assign out_valid = v_q[G-1];
      assign s         = s_q[G-1];
      assign cout      = c_q[G-1];
      assign ovf       = (x_q[G-1][MSB] == y_q[G-1][MSB]) &&
                         (s_q[G-1][MSB] != x_q[G-1][MSB]);
    end else begin : g_comb
      logic [WIDTH-1:0] s_c, s_q;
      logic [G:0]       ch;
      logic             ovf_c, c_q, o_q, v_q;

      assign ch[0] = ce;
      for (genvar k = 0; k < G; k++) begin : g_grp
        localparam int LO = grp_lo(k);
        localparam int GW = grp_w(k);
        scb_csla_grp #(.GW(GW), .FIRST(k == 0)) u_grp (
          .a_i (x[LO +: GW]),
          .b_i (ye[LO +: GW]),
          .c_i (ch[k]),
          .s_o (s_c[LO +: GW]),
          .c_o (ch[k+1])
        );
      end

      assign ovf_c = (x[MSB] == ye[MSB]) && (s_c[MSB] != x[MSB]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          s_q <= '0;
          c_q <= 1'b0;
          o_q <= 1'b0;
        end else if (en) begin
          v_q <= in_valid;
          s_q <= s_c;
          c_q <= ch[G];
          o_q <= ovf_c;
        end
      end

      assign out_valid = v_q;
      assign s         = s_q;
      assign cout      = c_q;
      assign ovf       = o_q;
    end
  endgenerate
endmodule

// File: tb/tb_scb_csla_pipe.sv
// Directed bench for scb_csla_pipe: 8-bit pipelined/combinational, 16-bit
// backpressure, 32-bit streaming and asynchronous reset mid-flight.

module tb_scb_csla_pipe;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit inputs shared by the pipelined and combinational instances
  logic       iv8, cin8, sub8, ordy8;
  logic [7:0] x8, y8;
  logic       ir8p, ov8p, co8p, of8p, ir8c, ov8c, co8c, of8c;
  logic [7:0] s8p, s8c;

  logic        iv16, cin16, sub16, ordy16, ir16, ov16, co16, of16;
  logic [15:0] x16, y16, s16;

  logic        iv32, cin32, sub32, ordy32, ir32, ov32, co32, of32;
  logic [31:0] x32, y32, s32;

  scb_csla_pipe #(.WIDTH(8), .PIPE(1)) dut8p (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8p), .x(x8), .y(y8),
    .cin(cin8), .sub(sub8), .out_valid(ov8p), .out_ready(ordy8), .s(s8p),
    .cout(co8p), .ovf(of8p));

  scb_csla_pipe #(.WIDTH(8), .PIPE(0)) dut8c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8c), .x(x8), .y(y8),
    .cin(cin8), .sub(sub8), .out_valid(ov8c), .out_ready(ordy8), .s(s8c),
    .cout(co8c), .ovf(of8c));

  scb_csla_pipe #(.WIDTH(16), .PIPE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .s(s16),
    .cout(co16), .ovf(of16));

  scb_csla_pipe #(.WIDTH(32), .PIPE(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .x(x32), .y(y32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32), .s(s32),
    .cout(co32), .ovf(of32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic c,
                              input logic sb, input logic [31:0] es, input logic ec,
                              input logic eo);
    vec_t v;
    v.x = a; v.y = b; v.cin = c; v.sub = sb; v.es = es; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  // Arithmetic reference for the random stream: returns {ovf, cout, s}
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c,
                                        input logic sb);
    logic [63:0] m, ye, full, sm;
    logic        co, ov;
    m    = (64'd1 << w) - 64'd1;
    ye   = (sb ? ~{32'd0, b} : {32'd0, b}) & m;
    full = ({32'd0, a} & m) + ye + (sb ? 64'd1 : {63'd0, c});
    sm   = full & m;
    co   = full[w];
    ov   = (a[w-1] == ye[w-1]) && (sm[w-1] != a[w-1]);
    return {ov, co, sm[31:0]};
  endfunction

  vec_t        tbl8 [10];
  vec_t        tbl16 [8];
  logic [31:0] rx [10];
  logic [31:0] ry [10];
  logic        rc [10];
  logic        rs [10];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n, idx, ri;
    logic acc, xfer, stall;
    logic [15:0] hold_s;
    logic [33:0] e;

    tbl8[0] = mk(32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    tbl8[1] = mk(32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
    tbl8[2] = mk(32'h80, 32'h01, 1'b1, 1'b1, 32'h7F, 1'b1, 1'b1);
    tbl8[3] = mk(32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0);
    tbl8[4] = mk(32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0);
    tbl8[5] = mk(32'h3C, 32'h0F, 1'b1, 1'b0, 32'h4C, 1'b0, 1'b0);
    tbl8[6] = mk(32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1);
    tbl8[7] = mk(32'h00, 32'h00, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0);
    tbl8[8] = mk(32'hAA, 32'h55, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    tbl8[9] = mk(32'hA5, 32'h5A, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);

    tbl16[0] = mk(32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0);
    tbl16[1] = mk(32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
    tbl16[2] = mk(32'h8000, 32'h8000, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1);
    tbl16[3] = mk(32'h0001, 32'h0002, 1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b0);
    tbl16[4] = mk(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    tbl16[5] = mk(32'hABCD, 32'h1234, 1'b0, 1'b0, 32'hBE01, 1'b0, 1'b0);
    tbl16[6] = mk(32'h1000, 32'h0001, 1'b0, 1'b1, 32'h0FFF, 1'b1, 1'b0);
    tbl16[7] = mk(32'hF0F0, 32'h0F0F, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rx[i] = $urandom; ry[i] = $urandom;
      rc[i] = 1'($urandom_range(0, 1)); rs[i] = 1'($urandom_range(0, 1));
    end

    iv8 = 0; x8 = 0; y8 = 0; cin8 = 0; sub8 = 0; ordy8 = 1;
    iv16 = 0; x16 = 0; y16 = 0; cin16 = 0; sub16 = 0; ordy16 = 1;
    iv32 = 0; x32 = 0; y32 = 0; cin32 = 0; sub32 = 0; ordy32 = 1;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state
    chk("rst_ov8p", ov8p, 0); chk("rst_s8p", s8p, 0); chk("rst_co8p", co8p, 0);
    chk("rst_of8p", of8p, 0); chk("rst_ir8p", ir8p, 1);
    chk("rst_ov8c", ov8c, 0); chk("rst_s8c", s8c, 0); chk("rst_ir8c", ir8c, 1);
    chk("rst_ov16", ov16, 0); chk("rst_s16", s16, 0); chk("rst_ir16", ir16, 1);
    chk("rst_ov32", ov32, 0); chk("rst_s32", s32, 0); chk("rst_of32", of32, 0);

    // Single operations: PIPE=0 visible after the accept edge, PIPE=1 two edges later
    for (int i = 0; i < 10; i++) begin
      x8 = tbl8[i].x[7:0]; y8 = tbl8[i].y[7:0];
      cin8 = tbl8[i].cin; sub8 = tbl8[i].sub; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      chk($sformatf("t8c_valid[%0d]", i), ov8c, 1);
      chk($sformatf("t8c_s[%0d]", i), s8c, tbl8[i].es[7:0]);
      chk($sformatf("t8c_cout[%0d]", i), co8c, tbl8[i].ec);
      chk($sformatf("t8c_ovf[%0d]", i), of8c, tbl8[i].eo);
      lat = 0;
      while (!ov8p && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("t8p_lat[%0d]", i), lat, 2);
      chk($sformatf("t8p_s[%0d]", i), s8p, tbl8[i].es[7:0]);
      chk($sformatf("t8p_cout[%0d]", i), co8p, tbl8[i].ec);
      chk($sformatf("t8p_ovf[%0d]", i), of8p, tbl8[i].eo);
      @(posedge clk); #1;
    end

    // 32-bit back-to-back stream, first result 6 edges after the first accept
    n = 0;
    for (int c = 0; c < 22; c++) begin
      iv32 = (c < 10);
      if (c < 10) begin
        x32 = rx[c]; y32 = ry[c]; cin32 = rc[c]; sub32 = rs[c];
      end
      @(posedge clk); #1;
      chk($sformatf("b2b_inrdy[%0d]", c), ir32, 1);
      if (ov32 && n < 10) begin
        e = model(32, rx[n], ry[n], rc[n], rs[n]);
        chk($sformatf("b2b_cycle[%0d]", n), c, n + 6);
        chk($sformatf("b2b_s[%0d]", n), s32, e[31:0]);
        chk($sformatf("b2b_cout[%0d]", n), co32, e[32]);
        chk($sformatf("b2b_ovf[%0d]", n), of32, e[33]);
        n++;
      end
    end
    iv32 = 1'b0;
    chk("b2b_count", n, 10);

    // 16-bit stream with out_ready low for 4 cycles mid-stream
    idx = 0; ri = 0;
    for (int c = 0; c < 40; c++) begin
      ordy16 = !(c >= 8 && c < 12);
      iv16 = (idx < 8);
      if (idx < 8) begin
        x16 = tbl16[idx].x[15:0]; y16 = tbl16[idx].y[15:0];
        cin16 = tbl16[idx].cin; sub16 = tbl16[idx].sub;
      end
      #1;
      acc = iv16 && ir16;
      xfer = ov16 && ordy16;
      stall = ov16 && !ordy16;
      hold_s = s16;
      if (stall) chk($sformatf("bp_inrdy[%0d]", c), ir16, 0);
      if (xfer && ri < 8) begin
        chk($sformatf("bp_s[%0d]", ri), s16, tbl16[ri].es[15:0]);
        chk($sformatf("bp_cout[%0d]", ri), co16, tbl16[ri].ec);
        chk($sformatf("bp_ovf[%0d]", ri), of16, tbl16[ri].eo);
        ri++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      if (stall) begin
        chk($sformatf("bp_hold_s[%0d]", c), s16, hold_s);
        chk($sformatf("bp_hold_v[%0d]", c), ov16, 1);
      end
    end
    iv16 = 1'b0; ordy16 = 1'b1;
    chk("bp_accepted", idx, 8);
    chk("bp_results", ri, 8);

    // Reset between edges with one result showing and two operations in flight
    x8 = 8'h11; y8 = 8'h22; cin8 = 0; sub8 = 0; iv8 = 1'b1;
    @(posedge clk); #1;
    x8 = 8'h01; y8 = 8'h01;
    @(posedge clk); #1;
    x8 = 8'h02; y8 = 8'h02;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("mr_pre_valid", ov8p, 1);
    chk("mr_pre_s", s8p, 8'h33);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_valid", ov8p, 0); chk("mr_s", s8p, 0);
    chk("mr_cout", co8p, 0); chk("mr_ovf", of8p, 0);
    chk("mr_valid_c", ov8c, 0);
    #2 rst_n = 1'b1;
    x8 = 8'h12; y8 = 8'h34; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8p && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mr_new_lat", lat, 2);
    chk("mr_new_s", s8p, 8'h46);
    chk("mr_new_cout", co8p, 0);
    @(posedge clk); #1;
    chk("mr_no_dup", ov8p, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scb_csla_pipe.md
Name: scb_csla_pipe

Overview:
- Parametrised square-root carry-select adder/subtractor; next generation of the fixed-width 8/16/32-bit SQRT CSLA blocks.
- Each group computes its sum with carry-in 0, derives the carry-in-1 result through a BEC, and selects between the two on the incoming group carry.
- Adds an optional register stage at every group boundary, a valid/ready handshake with backpressure, a subtract mode and a signed-overflow flag.
- Sits in the Karatsuba partial-product recombination path as the shared wide adder.

Parameters:
- WIDTH, 32, operand width in bits; minimum 4.
- PIPE, 1, pipelining mode.
  - 1: register after every group.
  - 0: combinational chain with a single output register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0 gives x+y+cin; 1 gives x-y.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry-out. In subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- **Group partition** (fixed at elaboration):
  - g0 = 2 bits.
  - Each later group is one bit wider than the previous one.
  - The final group takes the remaining bits, from 1 bit up to a full group.
  - G = number of groups. Examples: WIDTH=8 gives 2,3,3 (G=3); 16 gives 2,3,4,5,2 (G=5); 32 gives 2,3,4,5,6,7,5 (G=7).
- **Per-group datapath**:
  - g0 is a plain ripple/CLA add using the effective carry-in.
  - Every other group computes {c0,sum0} with carry-in 0, then {c1,sum1} = {c0,sum0}+1 via the BEC.
  - The group output is mux(sel = carry from the previous group).
- **Subtract mode**:
  - Effective operand is y' = ~y; effective carry-in is 1.
  - When sub=0, y' = y and the effective carry-in is cin.
- **Overflow**: ovf = (x[MSB]==y'[MSB]) && (s[MSB]!=x[MSB]).
- **Stall rule**:
  - Global advance enable is en = !out_valid || out_ready.
  - in_ready = en; the block is purely combinational from out_valid and out_ready.
  - An operand is accepted on a rising edge where in_valid && in_ready.
- **PIPE=1 timing**:
  - Stage k registers the group-k result and group-k carry.
  - Operand bits of groups above k, the sub flag and x[MSB]/y'[MSB] are delayed alongside.
  - Stage G-1 drives s, cout and ovf.
  - Latency is G cycles from the accepting edge to out_valid=1.
  - Throughput is one result per cycle when out_ready=1.
  - A per-stage valid bit travels with the data.
  - Bubbles (stage valid=0) still advance when en=1.
- **PIPE=0 timing**:
  - The full chain is combinational into one register.
  - Latency is 1 cycle; throughput is 1 per cycle.
- **Stall**:
  - With out_valid=1 && out_ready=0, all stage registers hold.
  - s, cout and ovf stay stable, and in_ready=0.
- **Handshake rules**:
  - Results leave in acceptance order with no drop or duplication.
  - Simultaneous accept and output on the same edge is legal and required for full throughput.
- **Reset**:
  - Asynchronous on rst_n low, including mid-operation.
  - Clears all stage valid bits, out_valid=0, s=0, cout=0, ovf=0.
  - In-flight operations are discarded.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Stage data registers other than the outputs need no reset.

Test Plan:
- **Add, carry out** (WIDTH=8, PIPE=1, out_ready=1): x=0xFF, y=0x01, cin=0, sub=0 -> after 3 cycles, out_valid=1, s=0x00, cout=1, ovf=0.
- **Signed overflow and subtract** (WIDTH=8):
  - x=0x7F, y=0x01, sub=0 -> s=0x80, cout=0, ovf=1.
  - x=0x80, y=0x01, sub=1, cin=1 -> s=0x7F, cout=1, ovf=1. The cin value is ignored.
- **Back-to-back throughput** (WIDTH=32, PIPE=1): 10 consecutive random pairs with in_valid held high -> first result 7 cycles after the first accept, then one result per cycle matching a reference model; in_ready stays 1 throughout.
- **Backpressure** (WIDTH=16, PIPE=1):
  - Stream 8 operations and drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, s is held stable, and all 8 results emerge in order.
  - A case with x=0xFFFF, y=0x0000, cin=1 -> s=0x0000, cout=1.
- **Reset mid-flight** (WIDTH=8, PIPE=1): assert rst_n low between clock edges with 2 operations in flight -> out_valid=0 and s=0 immediately; after release, no stale results appear and a new x=0x12, y=0x34 gives s=0x46 after 3 cycles.
- **PIPE=0** (WIDTH=8): x=0xA5, y=0x5A, cin=1 -> s=0x00, cout=1, ovf=0, out_valid 1 cycle after the accept edge.
